// File: rtl/hdlc_tx_framer_if.sv
// ---------------------------------------------------------------------------
// hdlc_tx_framer_if
// Groups the byte-source handshake and the serial outputs of the HDLC
// transmit framer.
//   Tx_ValidFrame   source -> framer : frame still has bytes to send
//   Tx_Data[7:0]    source -> framer : next payload byte
//   Tx_AbortFrame   source -> framer : abort request (level)
//   Tx_NewByte      framer -> source : Tx_Data consumed at this posedge
//   Tx              framer -> line   : serial bit, LSB first
//   Tx_AbortedTrans framer -> source : pulse on first abort-pattern bit
//   Tx_FrameDone    framer -> source : pulse on last closing-flag bit
// master = byte source, slave = framer.
// ---------------------------------------------------------------------------
interface hdlc_tx_framer_if;
    logic       Tx_ValidFrame;
    logic [7:0] Tx_Data;
    logic       Tx_AbortFrame;
    logic       Tx_NewByte;
    logic       Tx;
    logic       Tx_AbortedTrans;
    logic       Tx_FrameDone;

    modport master (
        output Tx_ValidFrame,
        output Tx_Data,
        output Tx_AbortFrame,
        input  Tx_NewByte,
        input  Tx,
        input  Tx_AbortedTrans,
        input  Tx_FrameDone
    );

    modport slave (
        input  Tx_ValidFrame,
        input  Tx_Data,
        input  Tx_AbortFrame,
        output Tx_NewByte,
        output Tx,
        output Tx_AbortedTrans,
        output Tx_FrameDone
    );
endinterface

// File: rtl/hdlc_tx_framer.sv
// ---------------------------------------------------------------------------
// hdlc_tx_framer
// Serialises a byte stream into an HDLC frame: opening flag, zero-stuffed
// payload (LSB first), closing flag. An abort request replaces the rest of
// the frame with the abort pattern 0,1111111.
// Ports:
//   Clk  : clock, all state changes on its rising edge
//   Rst  : asynchronous active-low reset
//   bus  : hdlc_tx_framer_if.slave (byte handshake + serial outputs)
// The registered state always describes the bit currently on Tx; the
// combinational block computes the bit (and state) for the next cycle.
// ---------------------------------------------------------------------------
module hdlc_tx_framer (
    input  logic              Clk,
    input  logic              Rst,
    hdlc_tx_framer_if.slave   bus
);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_OPEN_FLAG  = 3'd1;
    localparam logic [2:0] S_DATA       = 3'd2;
    localparam logic [2:0] S_STUFF      = 3'd3;
    localparam logic [2:0] S_CLOSE_FLAG = 3'd4;
    localparam logic [2:0] S_ABORT      = 3'd5;

    logic [2:0] r_state;
    logic [2:0] r_bit_cnt;      // index of the flag/abort/data bit on Tx
    logic [2:0] r_ones;         // consecutive data ones, including Tx bit
    logic [7:0] r_shift;        // payload bits still to be sent
    logic       r_tx;
    logic       r_aborted;
    logic       r_frame_done;

    logic [2:0] w_next_state;
    logic [2:0] w_next_bit;
    logic [2:0] w_next_ones;
    logic [7:0] w_next_shift;
    logic       w_next_tx;
    logic       w_new_byte;
    logic       w_abort;
    logic       w_field_end;

    // Flag pattern 0,1,1,1,1,1,1,0 indexed by bit position.
    function automatic logic flag_bit(input logic [2:0] idx);
        return !((idx == 3'd0) || (idx == 3'd7));
    endfunction

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves one unassigned; otherwise synthesis infers a latch.
        w_next_state = r_state;
        w_next_bit   = r_bit_cnt;
        w_next_ones  = r_ones;
        w_next_shift = r_shift;
        w_next_tx    = 1'b1;
        w_new_byte   = 1'b0;
        w_field_end  = 1'b0;

        // Abort only acts while a frame is on the line, and wins over
        // stuffing, byte fetch and closing.
        w_abort = bus.Tx_AbortFrame && (r_state != S_IDLE) && (r_state != S_ABORT);

        if (w_abort) begin
            w_next_state = S_ABORT;
            w_next_bit   = 3'd0;
            w_next_ones  = 3'd0;
            w_next_tx    = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.Tx_ValidFrame) begin
                        w_next_state = S_OPEN_FLAG;
                        w_next_bit   = 3'd0;
                        w_next_ones  = 3'd0;
                        w_next_tx    = 1'b0;
                    end
                end

                S_OPEN_FLAG: begin
                    if (r_bit_cnt == 3'd7) begin
                        w_field_end = 1'b1;
                    end else begin
                        w_next_bit = r_bit_cnt + 3'd1;
                        w_next_tx  = flag_bit(r_bit_cnt + 3'd1);
                    end
                end

                S_DATA, S_STUFF: begin
                    if ((r_state == S_DATA) && (r_ones == 3'd5)) begin
                        // Stuffed zero: shift register and bit index hold.
                        w_next_state = S_STUFF;
                        w_next_ones  = 3'd0;
                        w_next_tx    = 1'b0;
                    end else if (r_bit_cnt == 3'd7) begin
                        // Last data bit, or the stuff bit that follows it.
                        w_field_end = 1'b1;
                    end else begin
                        w_next_state = S_DATA;
                        w_next_bit   = r_bit_cnt + 3'd1;
                        w_next_tx    = r_shift[0];
                        w_next_shift = {1'b0, r_shift[7:1]};
                        w_next_ones  = r_shift[0] ? (r_ones + 3'd1) : 3'd0;
                    end
                end

                S_CLOSE_FLAG: begin
                    if (r_bit_cnt == 3'd7) begin
                        // Back-to-back frames share no idle bits.
                        if (bus.Tx_ValidFrame) begin
                            w_next_state = S_OPEN_FLAG;
                            w_next_bit   = 3'd0;
                            w_next_tx    = 1'b0;
                        end else begin
                            w_next_state = S_IDLE;
                        end
                    end else begin
                        w_next_bit = r_bit_cnt + 3'd1;
                        w_next_tx  = flag_bit(r_bit_cnt + 3'd1);
                    end
                end

                S_ABORT: begin
                    // A new frame must be requested from IDLE.
                    if (r_bit_cnt == 3'd7) begin
                        w_next_state = S_IDLE;
                    end else begin
                        w_next_bit = r_bit_cnt + 3'd1;
                    end
                end

                default: begin
                    w_next_state = S_IDLE;
                    w_next_bit   = 3'd0;
                    w_next_ones  = 3'd0;
                end
            endcase

            if (w_field_end) begin
                if (bus.Tx_ValidFrame) begin
                    // Fetch the next byte; its bit 0 goes out next cycle.
                    // The ones run carries across byte boundaries.
                    w_new_byte   = 1'b1;
                    w_next_state = S_DATA;
                    w_next_bit   = 3'd0;
                    w_next_tx    = bus.Tx_Data[0];
                    w_next_shift = {1'b0, bus.Tx_Data[7:1]};
                    w_next_ones  = bus.Tx_Data[0] ? (r_ones + 3'd1) : 3'd0;
                end else begin
                    w_next_state = S_CLOSE_FLAG;
                    w_next_bit   = 3'd0;
                    w_next_ones  = 3'd0;
                    w_next_tx    = 1'b0;
                end
            end
        end
    end

    // NOTE: the shift register sits on the reset too; it is a handful of
    // flops, and a known value keeps the line deterministic after reset.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state      <= S_IDLE;
            r_bit_cnt    <= 3'd0;
            r_ones       <= 3'd0;
            r_shift      <= 8'h00;
            r_tx         <= 1'b1;
            r_aborted    <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples the same
            // pre-edge values regardless of statement order.
            r_state      <= w_next_state;
            r_bit_cnt    <= w_next_bit;
            r_ones       <= w_next_ones;
            r_shift      <= w_next_shift;
            r_tx         <= w_next_tx;
            r_aborted    <= (w_next_state == S_ABORT) && (w_next_bit == 3'd0);
            r_frame_done <= (w_next_state == S_CLOSE_FLAG) && (w_next_bit == 3'd7);
        end
    end

    assign bus.Tx_NewByte      = w_new_byte;
    assign bus.Tx              = r_tx;
    assign bus.Tx_AbortedTrans = r_aborted;
    assign bus.Tx_FrameDone    = r_frame_done;

endmodule

// File: tb/tb_hdlc_tx_framer.sv
// ---------------------------------------------------------------------------
// tb_hdlc_tx_framer
// Directed bench for hdlc_tx_framer. Inputs change 1 ns after a rising edge;
// outputs are compared 2 ns after it. Expected bit streams are written out
// by hand, first transmitted bit on the left.
// ---------------------------------------------------------------------------
module tb_hdlc_tx_framer;

    logic Clk;
    logic Rst;
    int   n_checks;
    int   n_errors;

    hdlc_tx_framer_if bus ();

    hdlc_tx_framer dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Compare all outputs for the current cycle, then advance one cycle.
    // Called at edge+1; leaves the bench at the next edge+1.
    task automatic cyc(input string tag, input logic etx, input logic enb,
                       input logic efd, input logic eab);
        #1;
        check({tag, ".tx"}, bus.Tx, etx);
        check({tag, ".nb"}, bus.Tx_NewByte, enb);
        check({tag, ".fd"}, bus.Tx_FrameDone, efd);
        check({tag, ".ab"}, bus.Tx_AbortedTrans, eab);
        @(posedge Clk);
        #1;
    endtask

    // n cycles; bit n-1 of each vector is the first cycle.
    task automatic seq(input string tag, input int n, input logic [31:0] tx,
                       input logic [31:0] nb, input logic [31:0] fd,
                       input logic [31:0] ab);
        for (int i = n - 1; i >= 0; i--) begin
            cyc($sformatf("%s%0d", tag, n - 1 - i), tx[i], nb[i], fd[i], ab[i]);
        end
    endtask

    task automatic idle_cycles(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            cyc($sformatf("%s%0d", tag, i), 1'b1, 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        bus.Tx_ValidFrame = 1'b0;
        bus.Tx_Data       = 8'h00;
        bus.Tx_AbortFrame = 1'b0;
        Rst = 1'b1;
        #1;
        Rst = 1'b0;
        #1;
        check("rst.tx", bus.Tx, 1'b1);
        check("rst.nb", bus.Tx_NewByte, 1'b0);
        check("rst.fd", bus.Tx_FrameDone, 1'b0);
        check("rst.ab", bus.Tx_AbortedTrans, 1'b0);
        @(posedge Clk);
        #1;
        Rst = 1'b1;
        idle_cycles("post_rst", 3);

        // Single 0x00 byte, valid dropped after it is fetched.
        bus.Tx_ValidFrame = 1'b1;
        bus.Tx_Data       = 8'h00;
        cyc("b00.idle", 1'b1, 1'b0, 1'b0, 1'b0);
        seq("b00.open", 8, 32'b01111110, 32'b00000001, 32'b0, 32'b0);
        bus.Tx_ValidFrame = 1'b0;
        seq("b00.data", 8, 32'b00000000, 32'b0, 32'b0, 32'b0);
        seq("b00.close", 8, 32'b01111110, 32'b0, 32'b00000001, 32'b0);
        idle_cycles("b00.after", 2);

        // 0xFF: one stuffed zero after five ones.
        bus.Tx_ValidFrame = 1'b1;
        bus.Tx_Data       = 8'hFF;
        cyc("bff.idle", 1'b1, 1'b0, 1'b0, 1'b0);
        seq("bff.open", 8, 32'b01111110, 32'b00000001, 32'b0, 32'b0);
        bus.Tx_ValidFrame = 1'b0;
        seq("bff.data", 9, 32'b111110111, 32'b0, 32'b0, 32'b0);
        seq("bff.close", 8, 32'b01111110, 32'b0, 32'b00000001, 32'b0);
        idle_cycles("bff.after", 2);

        // 0x1F then 0x0F: stuff only in the first byte; second fetch on
        // the last data bit after the stuff.
        bus.Tx_ValidFrame = 1'b1;
        bus.Tx_Data       = 8'h1F;
        cyc("b1f.idle", 1'b1, 1'b0, 1'b0, 1'b0);
        seq("b1f.open", 8, 32'b01111110, 32'b00000001, 32'b0, 32'b0);
        bus.Tx_Data = 8'h0F;
        seq("b1f.data", 9, 32'b111110000, 32'b000000001, 32'b0, 32'b0);
        bus.Tx_ValidFrame = 1'b0;
        seq("b0f.data", 8, 32'b11110000, 32'b0, 32'b0, 32'b0);
        seq("b0f.close", 8, 32'b01111110, 32'b0, 32'b00000001, 32'b0);
        idle_cycles("b0f.after", 2);

        // Abort during the third data bit of 0xA5 (LSB first 1,0,1,...).
        bus.Tx_ValidFrame = 1'b1;
        bus.Tx_Data       = 8'hA5;
        cyc("abt.idle", 1'b1, 1'b0, 1'b0, 1'b0);
        seq("abt.open", 8, 32'b01111110, 32'b00000001, 32'b0, 32'b0);
        seq("abt.data", 2, 32'b10, 32'b0, 32'b0, 32'b0);
        bus.Tx_AbortFrame = 1'b1;
        cyc("abt.bit2", 1'b1, 1'b0, 1'b0, 1'b0);
        bus.Tx_AbortFrame = 1'b0;
        // Valid stays high through the pattern: no fetch, no restart.
        seq("abt.pat", 8, 32'b01111111, 32'b0, 32'b0, 32'b10000000);
        bus.Tx_ValidFrame = 1'b0;
        idle_cycles("abt.after", 4);

        // Empty frame from a one-cycle valid pulse.
        bus.Tx_ValidFrame = 1'b1;
        cyc("emp.idle", 1'b1, 1'b0, 1'b0, 1'b0);
        bus.Tx_ValidFrame = 1'b0;
        seq("emp.flags", 16, 32'b0111111001111110, 32'b0, 32'b1, 32'b0);
        idle_cycles("emp.after", 2);

        // Abort ignored in IDLE when a frame starts; back-to-back frames.
        bus.Tx_ValidFrame = 1'b1;
        bus.Tx_AbortFrame = 1'b1;
        cyc("b2b.idle", 1'b1, 1'b0, 1'b0, 1'b0);
        bus.Tx_AbortFrame = 1'b0;
        bus.Tx_ValidFrame = 1'b0;
        seq("b2b.f1", 15, 32'b011111100111111, 32'b0, 32'b0, 32'b0);
        bus.Tx_ValidFrame = 1'b1;
        cyc("b2b.last", 1'b0, 1'b0, 1'b1, 1'b0);
        bus.Tx_ValidFrame = 1'b0;
        seq("b2b.f2", 16, 32'b0111111001111110, 32'b0, 32'b1, 32'b0);
        idle_cycles("b2b.after", 2);

        // Reset in the middle of the data field.
        bus.Tx_ValidFrame = 1'b1;
        bus.Tx_Data       = 8'h00;
        cyc("mrst.idle", 1'b1, 1'b0, 1'b0, 1'b0);
        seq("mrst.open", 8, 32'b01111110, 32'b00000001, 32'b0, 32'b0);
        seq("mrst.data", 3, 32'b000, 32'b0, 32'b0, 32'b0);
        Rst = 1'b0;
        #1;
        check("mrst.async.tx", bus.Tx, 1'b1);
        check("mrst.async.nb", bus.Tx_NewByte, 1'b0);
        @(posedge Clk);
        #1;
        check("mrst.held.tx", bus.Tx, 1'b1);
        check("mrst.held.nb", bus.Tx_NewByte, 1'b0);
        Rst = 1'b1;
        bus.Tx_ValidFrame = 1'b0;
        idle_cycles("mrst.after", 4);
        bus.Tx_ValidFrame = 1'b1;
        cyc("mrst.new.idle", 1'b1, 1'b0, 1'b0, 1'b0);
        seq("mrst.new.open", 8, 32'b01111110, 32'b00000001, 32'b0, 32'b0);
        bus.Tx_ValidFrame = 1'b0;
        seq("mrst.new.data", 8, 32'b00000000, 32'b0, 32'b0, 32'b0);
        seq("mrst.new.close", 8, 32'b01111110, 32'b0, 32'b00000001, 32'b0);
        idle_cycles("mrst.new.after", 2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
